// File: rtl/ifetch_mem_responder_pkg.sv
// Shared constants, FSM encoding and address-check helper for the instruction
// memory responder.
package ifetch_mem_responder_pkg;

  localparam logic [1:0]  RESP_OKAY    = 2'b00;
  localparam logic [1:0]  RESP_SLVERR  = 2'b10;
  localparam logic [31:0] RESET_VECTOR = 32'h8000_0000;
  localparam logic [31:0] ZERO_DATA    = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // True when a byte address cannot be mapped onto a word of the array.
  // The offset wraps mod 2^32, so the explicit below-base test keeps low
  // addresses from aliasing into the top of the array.
  function automatic logic addr_err(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] depth);
    logic [31:0] off;
    off = addr - base;
    return (addr[1:0] != 2'b00) || (addr < base) || ((off >> 2) >= depth);
  endfunction

endpackage

// File: rtl/ifetch_mem_array.sv
// Word storage with one synchronous write port and a registered read port
// that captures only on a read enable.
module ifetch_mem_array
  import ifetch_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic          rzero,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Contents survive reset; only the read register is cleared.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  // Nonblocking semantics give read-old-data on a same-edge write.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)  rdata <= ZERO_DATA;
    else if (re) rdata <= rzero ? ZERO_DATA : mem[raddr];
  end

endmodule

// File: rtl/ifetch_mem_responder.sv
// Instruction-memory read responder: AR/R handshake, programmable latency,
// SLVERR on unmapped addresses, side preload port.
module ifetch_mem_responder
  import ifetch_mem_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = RESET_VECTOR,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] araddr_i,
  input  logic        arvalid_i,
  output logic        arready_o,
  output logic [31:0] rdata_o,
  output logic [1:0]  rresp_o,
  output logic        rvalid_o,
  input  logic        rready_i,
  input  logic        ld_we_i,
  input  logic [31:0] ld_addr_i,
  input  logic [31:0] ld_data_i
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e        state;
  logic [3:0]    cnt;
  logic          ar_hs;
  logic          rd_err, ld_err;
  logic [31:0]   rd_off, ld_off;
  logic [AW-1:0] rd_idx, ld_idx;

  assign ar_hs  = arvalid_i && arready_o;
  assign rd_err = addr_err(araddr_i, BASE_ADDR, 32'(DEPTH_WORDS));
  assign ld_err = addr_err(ld_addr_i, BASE_ADDR, 32'(DEPTH_WORDS));
  assign rd_off = araddr_i - BASE_ADDR;
  assign ld_off = ld_addr_i - BASE_ADDR;
  assign rd_idx = AW'(rd_off >> 2);
  assign ld_idx = AW'(ld_off >> 2);

  ifetch_mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clock (clock),
    .reset (reset),
    .we    (ld_we_i && !ld_err),
    .waddr (ld_idx),
    .wdata (ld_data_i),
    .re    (ar_hs),
    .rzero (rd_err),
    .raddr (rd_idx),
    .rdata (rdata_o)
  );

  // The handshake edge only samples the array; WAIT always spends at least
  // one cycle so rvalid rises LATENCY+1 edges after acceptance.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      arready_o <= 1'b0;
      rvalid_o  <= 1'b0;
      rresp_o   <= RESP_OKAY;
      cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ar_hs) begin
            arready_o <= 1'b0;
            rresp_o   <= rd_err ? RESP_SLVERR : RESP_OKAY;
            cnt       <= 4'(LATENCY);
            state     <= ST_WAIT;
          end else begin
            arready_o <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            rvalid_o <= 1'b1;
            state    <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (rready_i) begin
            rvalid_o  <= 1'b0;
            arready_o <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          arready_o <= 1'b0;
          rvalid_o  <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_mem_responder.sv
// Scoreboard bench for ifetch_mem_responder: a LATENCY=2 and a LATENCY=0
// instance driven by directed and random reads against a word-map model.
module tb_ifetch_mem_responder;

  localparam logic [31:0] BASE    = 32'h8000_0000;
  localparam longint      BASE_L  = 64'h8000_0000;
  localparam int          DEPTH_A = 4096;
  localparam int          DEPTH_B = 16;
  localparam int          LAT_A   = 2;
  localparam int          LAT_B   = 0;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] araddr = '0;
  logic        arvalid_a = 1'b0, arvalid_b = 1'b0;
  logic        rready_a = 1'b1, rready_b = 1'b1;
  logic        ld_we = 1'b0;
  logic [31:0] ld_addr = '0, ld_data = '0;
  logic        arready_a, arready_b, rvalid_a, rvalid_b;
  logic [31:0] rdata_a, rdata_b;
  logic [1:0]  rresp_a, rresp_b;

  always #5 clock = ~clock;

  ifetch_mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH_A), .LATENCY(LAT_A)) dut_a (
    .clock(clock), .reset(reset), .araddr_i(araddr), .arvalid_i(arvalid_a),
    .arready_o(arready_a), .rdata_o(rdata_a), .rresp_o(rresp_a), .rvalid_o(rvalid_a),
    .rready_i(rready_a), .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data));

  ifetch_mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH_B), .LATENCY(LAT_B)) dut_b (
    .clock(clock), .reset(reset), .araddr_i(araddr), .arvalid_i(arvalid_b),
    .arready_o(arready_b), .rdata_o(rdata_b), .rresp_o(rresp_b), .rvalid_o(rvalid_b),
    .rready_i(rready_b), .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data));

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    int          hs;
  } exp_t;

  exp_t        qa[$], qb[$];
  logic [31:0] mdl_a[int], mdl_b[int];
  int          checks = 0, failures = 0, cyc = 0;
  bit          rnd_rr = 0;
  bit          prev_rv_a = 0, prev_rv_b = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Byte address -> word slot of a memory of 'depth' words, or no slot.
  function automatic bit in_range(input logic [31:0] addr, input int depth, output int idx);
    longint a;
    a   = longint'({32'b0, addr});
    idx = 0;
    if (a % 4 != 0 || a < BASE_L || (a - BASE_L) / 4 >= depth) return 0;
    idx = int'((a - BASE_L) / 4);
    return 1;
  endfunction

  function automatic exp_t model_read(input int which, input logic [31:0] addr);
    exp_t e;
    int   idx;
    e.hs = 0;
    if (in_range(addr, which ? DEPTH_B : DEPTH_A, idx)) begin
      e.data = which ? mdl_b[idx] : mdl_a[idx];
      e.resp = 2'b00;
    end else begin
      e.data = 32'h0;
      e.resp = 2'b10;
    end
    return e;
  endfunction

  function automatic void model_ld(input logic [31:0] addr, input logic [31:0] data);
    int idx;
    if (in_range(addr, DEPTH_A, idx)) mdl_a[idx] = data;
    if (in_range(addr, DEPTH_B, idx)) mdl_b[idx] = data;
  endfunction

  task automatic rand_rready();
    if (rnd_rr) begin
      rready_a = ($urandom_range(0, 3) != 0);
      rready_b = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic ld_write(input logic [31:0] addr, input logic [31:0] data);
    ld_we = 1'b1; ld_addr = addr; ld_data = data;
    @(posedge clock); #1;
    model_ld(addr, data);
    ld_we = 1'b0;
  endtask

  // Presents one AR request and returns just after its handshake edge.
  task automatic ar_read(input int which, input logic [31:0] addr);
    exp_t e;
    int   n = 0;
    araddr = addr;
    if (which) arvalid_b = 1'b1; else arvalid_a = 1'b1;
    while (!(which ? arready_b : arready_a) && n < 60) begin
      @(posedge clock); #1; n++;
      rand_rready();
    end
    if (n >= 60) begin
      fail_now("ar_handshake_timeout");
    end else begin
      e    = model_read(which, addr);
      e.hs = cyc + 1;
      if (which) qb.push_back(e); else qa.push_back(e);
      @(posedge clock); #1;
    end
    arvalid_a = 1'b0; arvalid_b = 1'b0;
  endtask

  task automatic wait_arready(input int which, output int low);
    low = 0;
    while (!(which ? arready_b : arready_a) && low < 60) begin
      @(posedge clock); #1; low++;
      rand_rready();
    end
    if (low >= 60) fail_now("arready_timeout");
  endtask

  always @(negedge clock) begin
    if (reset) begin
      if (rvalid_a && arready_a) fail_now("a_arready_during_rvalid");
      if (rvalid_a) begin
        if (qa.size() == 0) fail_now("a_unexpected_rvalid");
        else begin
          if (!prev_rv_a) chk("a_latency", 32'(cyc - qa[0].hs), 32'(LAT_A + 1));
          chk("a_rdata", rdata_a, qa[0].data);
          chk("a_rresp", {30'b0, rresp_a}, {30'b0, qa[0].resp});
          if (rready_a) void'(qa.pop_front());
        end
      end
    end
    prev_rv_a = rvalid_a;
  end

  always @(negedge clock) begin
    if (reset) begin
      if (rvalid_b && arready_b) fail_now("b_arready_during_rvalid");
      if (rvalid_b) begin
        if (qb.size() == 0) fail_now("b_unexpected_rvalid");
        else begin
          if (!prev_rv_b) chk("b_latency", 32'(cyc - qb[0].hs), 32'(LAT_B + 1));
          chk("b_rdata", rdata_b, qb[0].data);
          chk("b_rresp", {30'b0, rresp_b}, {30'b0, qb[0].resp});
          if (rready_b) void'(qb.pop_front());
        end
      end
    end
    prev_rv_b = rvalid_b;
  end

  initial begin
    int          low, n, which, kind, depth;
    logic [31:0] addr;

    repeat (3) @(posedge clock);
    #1;
    chk("rst_arready_a", {31'b0, arready_a}, 32'd0);
    chk("rst_rvalid_a", {31'b0, rvalid_a}, 32'd0);
    chk("rst_rdata_a", rdata_a, 32'd0);
    chk("rst_rresp_a", {30'b0, rresp_a}, 32'd0);
    chk("rst_rvalid_b", {31'b0, rvalid_b}, 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("arready_after_reset", {31'b0, arready_a}, 32'd1);

    for (int i = 0; i < DEPTH_B; i++) ld_write(BASE + 32'(4 * i), $urandom);
    for (int i = DEPTH_B; i < 32; i++) ld_write(BASE + 32'(4 * i), $urandom);
    ld_write(BASE + 32'h0, 32'h0000_0413);
    ld_write(BASE + 32'h4, 32'h0010_0093);
    ld_write(BASE + 32'h8, 32'hAAAA_AAAA);
    ld_write(BASE + 32'(4 * (DEPTH_A - 1)), 32'hDEAD_BEEF);
    ld_write(BASE + 32'(4 * DEPTH_A), 32'h1234_5678);
    ld_write(BASE + 32'h1, 32'hFFFF_FFFF);

    // basic reads and accept-to-ready turnaround
    ar_read(0, BASE);
    wait_arready(0, low);
    chk("a_arready_low_cycles", 32'(low), 32'd4);
    ar_read(0, BASE + 32'h4);
    wait_arready(0, low);

    // backpressure: response must hold while rready is low
    rready_a = 1'b0;
    ar_read(0, BASE);
    n = 0;
    while (!rvalid_a && n < 20) begin @(posedge clock); #1; n++; end
    if (n >= 20) fail_now("bp_rvalid_timeout");
    repeat (5) begin
      @(posedge clock); #1;
      chk("bp_rvalid_held", {31'b0, rvalid_a}, 32'd1);
      chk("bp_arready_low", {31'b0, arready_a}, 32'd0);
    end
    rready_a = 1'b1;
    @(posedge clock); #1;
    chk("bp_release_rvalid", {31'b0, rvalid_a}, 32'd0);
    chk("bp_release_arready", {31'b0, arready_a}, 32'd1);

    // error decode boundaries
    ar_read(0, BASE + 32'h2);                   wait_arready(0, low);
    ar_read(0, 32'h7FFF_FFFC);                  wait_arready(0, low);
    ar_read(0, BASE + 32'(4 * DEPTH_A));        wait_arready(0, low);
    ar_read(0, BASE + 32'(4 * (DEPTH_A - 1)));  wait_arready(0, low);
    ar_read(0, 32'hFFFF_FFFC);                  wait_arready(0, low);

    // same-edge preload and read of one word returns the old contents
    araddr = BASE + 32'h8; arvalid_a = 1'b1;
    ld_we = 1'b1; ld_addr = BASE + 32'h8; ld_data = 32'h5555_5555;
    begin
      exp_t e;
      e    = model_read(0, BASE + 32'h8);
      e.hs = cyc + 1;
      qa.push_back(e);
    end
    @(posedge clock); #1;
    model_ld(BASE + 32'h8, 32'h5555_5555);
    ld_we = 1'b0; arvalid_a = 1'b0;
    wait_arready(0, low);
    ar_read(0, BASE + 32'h8);
    wait_arready(0, low);

    // asynchronous reset while a read is in WAIT
    ar_read(0, BASE + 32'h4);
    @(posedge clock); #2;
    reset = 1'b0;
    #1;
    chk("midrst_rvalid", {31'b0, rvalid_a}, 32'd0);
    chk("midrst_arready", {31'b0, arready_a}, 32'd0);
    qa.delete();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    chk("midrst_arready_back", {31'b0, arready_a}, 32'd1);
    repeat (6) @(posedge clock);
    #1;
    ar_read(0, BASE);
    wait_arready(0, low);

    // LATENCY=0 instance, back-to-back reads
    for (int i = 0; i < 10; i++) ar_read(1, BASE + 32'(4 * (i % DEPTH_B)));
    wait_arready(1, low);
    ar_read(1, BASE + 32'(4 * DEPTH_B));        wait_arready(1, low);
    ar_read(1, BASE + 32'(4 * (DEPTH_B - 1)));  wait_arready(1, low);

    // randomized reads, preloads and rready on both instances
    rnd_rr = 1;
    for (int i = 0; i < 80; i++) begin
      which = $urandom_range(0, 1);
      depth = which ? DEPTH_B : DEPTH_A;
      kind  = $urandom_range(0, 5);
      case (kind)
        0, 1: addr = BASE + 32'(4 * $urandom_range(0, 31 < depth ? 31 : depth - 1));
        2:    addr = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
        3:    addr = BASE - 32'(4 * $urandom_range(1, 100));
        4:    addr = BASE + 32'(4 * depth) + 32'(4 * $urandom_range(0, 1000));
        default: addr = BASE + 32'(4 * (depth - 1));
      endcase
      if ($urandom_range(0, 3) == 0) ld_write(BASE + 32'(4 * $urandom_range(0, 31)), $urandom);
      ar_read(which, addr);
    end
    rnd_rr = 0;
    rready_a = 1'b1; rready_b = 1'b1;

    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 200) begin @(posedge clock); #1; n++; end
    chk("drain_qa", 32'(qa.size()), 32'd0);
    chk("drain_qb", 32'(qb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
